logit_argmax_classifier: RTL and testbench

//  Consumes the final dense layer's class scores, streamed one signed logit per beat.

---
 rtl/logit_argmax_classifier.sv | 123 ++++++++++++
 tb/tb_logit_argmax_classifier.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/logit_argmax_classifier.sv
// Arg-max over a frame of N signed logits, streamed one per beat; reports class index, ASCII letter and winning value.
// Latency: result registered, out_valid rises 1 clk after the terminal beat; one-cycle bubble between frames.
// Backpressure: in_ready drops while a result waits; the result is held stable until out_ready accepts it.
module logit_argmax_classifier #(
    parameter int DW      = 71,
    parameter int N       = 25,
    parameter int IDXW    = 5,
    parameter int BAD_CLS = 9
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [DW-1:0]   in_data,
    input  logic            in_last,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [IDXW-1:0] out_idx,
    output logic [7:0]      out_letter,
    output logic [DW-1:0]   out_max,
    output logic            out_err,
    output logic            out_bad
);

    // One extra bit so the beat count reaches N without wrapping.
    localparam int CNTW = IDXW + 1;
    localparam logic [CNTW-1:0] N_C   = CNTW'(N);
    localparam logic [IDXW-1:0] BAD_C = IDXW'(BAD_CLS);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                 state, state_nxt;
    logic [CNTW-1:0]        cnt;
    logic [CNTW-1:0]        cnt_after;
    logic signed [DW-1:0]   max_r;
    logic [IDXW-1:0]        idx_r;
    logic signed [DW-1:0]   cand_max;
    logic [IDXW-1:0]        cand_idx;
    logic                   beat;
    logic                   terminal;
    logic                   err_nxt;
    logic                   bad_nxt;

    // Next-state, handshake and candidate running-max computation.
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        cand_max  = max_r;
        cand_idx  = idx_r;
        cnt_after = cnt + CNTW'(1);
        case (state)
            IDLE: begin
                // First beat of a frame seeds the running max unconditionally.
                in_ready  = 1'b1;
                cand_max  = $signed(in_data);
                cand_idx  = '0;
                cnt_after = CNTW'(1);
            end
            ACC: begin
                in_ready = 1'b1;
                // Strictly greater: ties keep the lower (earlier) index.
                if ($signed(in_data) > max_r) begin
                    cand_max = $signed(in_data);
                    cand_idx = cnt[IDXW-1:0];
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase

        beat     = in_valid && in_ready;
        terminal = beat && (in_last || (cnt_after == N_C));
        err_nxt  = !(in_last && (cnt_after == N_C));
        bad_nxt  = (cand_idx == BAD_C) || ({1'b0, cand_idx} >= N_C);

        if (beat) begin
            state_nxt = terminal ? DONE : ACC;
        end
    end

    assign out_valid = (state == DONE);

    // State, running max/index, beat counter and registered result.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            max_r      <= '0;
            idx_r      <= '0;
            out_idx    <= '0;
            out_letter <= 8'h41;
            out_max    <= '0;
            out_err    <= 1'b0;
            out_bad    <= 1'b0;
        end else begin
            state <= state_nxt;
            if (beat) begin
                max_r <= cand_max;
                idx_r <= cand_idx;
                cnt   <= cnt_after;
            end
            if (terminal) begin
                out_idx    <= cand_idx;
                out_letter <= 8'h41 + {{(8-IDXW){1'b0}}, cand_idx};
                out_max    <= cand_max;
                out_err    <= err_nxt;
                out_bad    <= bad_nxt;
            end
            if (state == DONE && out_ready) begin
                cnt <= '0;
            end
        end
    end

endmodule

// File: tb/tb_logit_argmax_classifier.sv
// Randomized scoreboard bench for logit_argmax_classifier against a software arg-max model.
// Latency: checks out_valid one clock after each terminal beat.
// Backpressure: exercises random and long out_ready stalls and checks result stability.
module tb_logit_argmax_classifier;

    localparam int DW = 71;
    localparam int N  = 25;
    localparam int IDXW = 5;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [DW-1:0]   in_data = '0;
    logic            in_last = 1'b0;
    logic            out_valid;
    logic            out_ready = 1'b0;
    logic [IDXW-1:0] out_idx;
    logic [7:0]      out_letter;
    logic [DW-1:0]   out_max;
    logic            out_err;
    logic            out_bad;

    logit_argmax_classifier #(.DW(DW), .N(N), .IDXW(IDXW), .BAD_CLS(9)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_idx(out_idx), .out_letter(out_letter), .out_max(out_max),
        .out_err(out_err), .out_bad(out_bad)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [IDXW-1:0] idx;
        logic [DW-1:0]   mx;
        bit              err;
        bit              bad;
    } exp_t;

    exp_t sb[$];
    logic signed [DW-1:0] frame[$];
    int checks = 0;
    int errors = 0;
    bit hold = 1'b0;
    bit rnd_rdy = 1'b0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: first index holding the largest value among the frame's beats.
    task automatic push_expected(input bit last);
        exp_t e;
        int best;
        best = 0;
        foreach (frame[i]) if (frame[i] > frame[best]) best = i;
        e.idx = IDXW'(best);
        e.mx  = frame[best];
        e.err = !(last && frame.size() == N);
        e.bad = (best == 9) || (best >= N);
        sb.push_back(e);
    endtask

    task automatic drive_beat(input logic signed [DW-1:0] d, input bit last);
        int n;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        n = 0;
        while (!in_ready && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) chk("in_ready_timeout", 0, 1);
        @(posedge clk);
        #1 in_valid = 1'b0;
        in_last = 1'b0;
    endtask

    // Sends the frame queue; in_last on the final beat when 'last' is set.
    task automatic send_frame(input bit last, input int maxgap);
        push_expected(last);
        foreach (frame[i]) begin
            repeat ($urandom_range(0, maxgap)) @(negedge clk);
            drive_beat(frame[i], last && (i == frame.size() - 1));
        end
        @(negedge clk);
        chk("out_valid_latency", out_valid, 1);
    endtask

    function automatic logic signed [DW-1:0] rnd_logit(input bit narrow);
        logic [95:0] r;
        if (narrow) return DW'($signed($urandom_range(0, 6)) - 3);
        r = {$urandom, $urandom, $urandom};
        return r[DW-1:0];
    endfunction

    // Downstream ready, changed away from both sampling points.
    always @(posedge clk) begin
        #2;
        if (hold) out_ready = 1'b0;
        else if (rnd_rdy) out_ready = 1'($urandom_range(0, 1));
        else out_ready = 1'b1;
    end

    // Monitor: stability while stalled, and scoreboard pop on each accepted result.
    logic [IDXW-1:0] s_idx;
    logic [7:0]      s_let;
    logic [DW-1:0]   s_max;
    logic            s_err, s_bad;
    bit              stalled = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            stalled = 1'b0;
        end else if (out_valid) begin
            chk("in_ready_while_valid", in_ready, 0);
            if (stalled) begin
                chk("stable_idx", out_idx, s_idx);
                chk("stable_letter", out_letter, s_let);
                chk("stable_max", out_max, s_max);
                chk("stable_flags", {out_err, out_bad}, {s_err, s_bad});
            end
            if (out_ready) begin
                stalled = 1'b0;
                if (sb.size() == 0) begin
                    chk("unexpected_result", 1, 0);
                end else begin
                    e = sb.pop_front();
                    chk("out_idx", out_idx, e.idx);
                    chk("out_letter", out_letter, 8'h41 + {3'b0, e.idx});
                    chk("out_max", out_max, e.mx);
                    chk("out_err", out_err, e.err);
                    chk("out_bad", out_bad, e.bad);
                end
            end else begin
                stalled = 1'b1;
                s_idx = out_idx; s_let = out_letter; s_max = out_max;
                s_err = out_err; s_bad = out_bad;
            end
        end else begin
            stalled = 1'b0;
        end
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
        $fatal(1);
    end

    initial begin
        int n;
        repeat (3) @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_idx", out_idx, 0);
        chk("rst_out_letter", out_letter, 8'h41);
        chk("rst_out_max", out_max, 0);
        chk("rst_flags", {out_err, out_bad}, 2'b00);
        rst = 1'b0;

        // Ascending ramp: winner is the last class.
        frame.delete();
        for (int k = 0; k < N; k++) frame.push_back(DW'(k * 10));
        send_frame(1'b1, 0);

        // All negative with a tie at -5 (indices 2 and 17).
        frame.delete();
        for (int k = 0; k < N; k++) frame.push_back(-DW'(100));
        frame[2] = -DW'(5);
        frame[17] = -DW'(5);
        send_frame(1'b1, 1);

        // Long stall: extra beats must be refused while the result waits.
        hold = 1'b1;
        frame.delete();
        for (int k = 0; k < N; k++) frame.push_back(rnd_logit(1'b0));
        send_frame(1'b1, 0);
        for (int k = 0; k < 10; k++) begin
            in_valid = 1'b1;
            in_data  = rnd_logit(1'b0);
            @(negedge clk);
            chk("stall_in_ready", in_ready, 0);
            chk("stall_out_valid", out_valid, 1);
        end
        in_valid = 1'b0;
        hold = 1'b0;
        n = 0;
        while (out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("release_idle_in_ready", in_ready, 1);
        chk("release_out_valid", out_valid, 0);

        // Short frame: 10 beats, max at class 9 -> 'J', err and bad.
        frame.delete();
        for (int k = 0; k < 10; k++) frame.push_back(DW'(k));
        send_frame(1'b1, 0);

        // Reset after 12 beats discards the partial frame.
        @(negedge clk);
        for (int k = 0; k < 12; k++) drive_beat(DW'(k + 1000), 1'b0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_in_ready", in_ready, 1);
        chk("midrst_out_letter", out_letter, 8'h41);
        rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("post_rst_no_valid", out_valid, 0);
        end
        frame.delete();
        frame.push_back(DW'(77));
        for (int k = 1; k < N; k++) frame.push_back(DW'(k));
        send_frame(1'b1, 0);

        // Back-to-back random frames with input gaps.
        for (int f = 0; f < 2; f++) begin
            frame.delete();
            for (int k = 0; k < N; k++) frame.push_back(rnd_logit(1'b0));
            send_frame(1'b1, 3);
        end

        // Random mix: variable length, missing in_last, ties, random out_ready.
        rnd_rdy = 1'b1;
        for (int f = 0; f < 30; f++) begin
            bit last;
            int len;
            bit narrow;
            last = ($urandom_range(0, 3) != 0);
            len  = last ? $urandom_range(1, N) : N;
            narrow = ($urandom_range(0, 1) == 1);
            frame.delete();
            for (int k = 0; k < len; k++) frame.push_back(rnd_logit(narrow));
            send_frame(last, 2);
        end
        rnd_rdy = 1'b0;

        n = 0;
        while (sb.size() != 0 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("scoreboard_drained", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
